link_scheduler: RTL and testbench
=================================

# link_scheduler

Arbitrates the single UART byte transmitter between the game's outgoing message sources (seed, start request, direction, heartbeat), framing each message as a 3-byte packet. It also runs a receive-side watchdog that drives `con_error` into mode control. It sits between the game logic (point generator, mode control, mouse/direction logic) and the `uart_tx` byte sender inside the communication path, on the 75 MHz `clk` domain.

## Interface
- `HB_CYCLES`, default 7_500_000: idle cycles with no frame sent before a heartbeat is scheduled (100 ms at 75 MHz).
- `TIMEOUT_CYCLES`, default 37_500_000: cycles without a received frame before `con_error` is raised (500 ms).
- `clk`  in  1  system clock; one clock domain only.
- `rst`  in  1  synchronous, active-high reset.
- `link_en`  in  1  watchdog and heartbeat enabled (high while in a networked mode).
- `seed_rdy`  in  1  one-cycle request to send a seed frame.
- `seed_x`, `seed_y`  in  5 each  seed payload; latched on `seed_rdy`.
- `start_req`  in  1  one-cycle request to send a start frame.
- `dir_tick`  in  1  one-cycle request to send a direction frame (game tick).
- `dir`  in  `direction` (2)  local direction; sampled at frame start, not at request.
- `rx_frame_valid`  in  1  one-cycle pulse per good frame from the receiver.
- `err_clear`  in  1  clears a sticky `con_error`.
- `tx_busy`  in  1  `uart_tx` busy.
- `tx_start`  out  1  one-cycle byte strobe to `uart_tx`.
- `tx_data`  out  8  byte to send; valid while `tx_start` is high.
- `frame_busy`  out  1  a frame is in progress.
- `frame_sent`  out  1  one-cycle pulse after the last byte of a frame completes.
- `con_error`  out  1  sticky link-loss flag.

## Operation
- Pending flags `p_seed`, `p_start`, `p_dir`, `p_hb`:
  - Set on the request pulse.
  - Cleared in the cycle the frame is selected.
  - A request that arrives during its own frame in flight sets the flag again, so one more frame follows.
  - A set and a clear of the same flag in the same cycle resolve to set.
- Priority on selection is fixed: seed > start > dir > heartbeat.
- Frame format: byte 0 header = `{4'hA, 2'b00, msg_type}`.
  - Seed: byte 1 = `{3'b0, seed_x}`, byte 2 = `{3'b0, seed_y}`.
  - Dir: byte 1 = `{6'b0, dir}`, byte 2 = 8'h00.
  - Start and heartbeat: bytes 1 and 2 = 8'h00.
- FSM states: IDLE, SEND, WAIT_ACK, WAIT_DONE.
  - IDLE → SEND when any flag is pending and `tx_busy` = 0. On that edge the frame's 3 bytes are latched and the byte index is set to 0.
  - SEND: `tx_start` = 1 and `tx_data` = byte[idx] for exactly one cycle, then → WAIT_ACK.
  - WAIT_ACK waits for `tx_busy` = 1, then → WAIT_DONE.
  - WAIT_DONE waits for `tx_busy` = 0. If idx < 2, idx increments and the FSM → SEND. Otherwise it pulses `frame_sent` and → IDLE.
- Heartbeat counter:
  - Counts cycles in IDLE with no pending flags, only while `link_en` = 1.
  - Resets on `frame_sent`, on `link_en` = 0, and on `rst`.
  - Reaching HB_CYCLES-1 sets `p_hb` and resets the counter.
- Watchdog counter:
  - Resets on `rx_frame_valid`, on `link_en` = 0, and on `rst`.
  - Increments otherwise, saturating at TIMEOUT_CYCLES.
  - Reaching TIMEOUT_CYCLES sets `con_error`.
- `con_error` is sticky. It clears only on `rst` or `err_clear`.
  - If `err_clear` and the timeout condition occur in the same cycle, clear wins and the counter restarts from 0.
- `link_en` falling does not abort a frame in progress. Pending flags are kept.

## Timing
- Reset values: state IDLE; all flags 0; `tx_start` 0; `tx_data` 8'h00; `frame_busy` 0; `frame_sent` 0; `con_error` 0; both counters 0.
- `rst` mid-frame abandons the frame immediately; the next cycle has reset values.
- Latency from request (cycle N, FSM idle, `tx_busy` = 0) to header `tx_start` is cycle N+2: flag set at N+1, SEND entered at N+2.
- `frame_busy` is high in every non-IDLE state.
- All outputs are registered.
- Counter widths are `$clog2(param+1)`.

## Structure
- Add to `snake_pkg`:
  - `msg_type` enum: START=0, SEED=1, DIR=2, HB=3.
  - `FRAME_HDR` = 4'hA.
  - `FRAME_LEN` = 3.
- The existing `direction` type is reused.
- One sub-module: `link_watchdog` (counter plus sticky `con_error`, parameterised by TIMEOUT_CYCLES).
- Scheduler FSM and heartbeat logic live in `link_scheduler`.

## Test plan
- Reset, then `seed_rdy` with x=5'd17, y=5'd3. Model `uart_tx` as 10 cycles busy per byte. Required: `tx_data` = 0xA1, 0x11, 0x03 in order, then `frame_sent` = 1 once.
- `seed_rdy`, `start_req` and `dir_tick` in the same cycle with `dir` = 2. Required: frames in order seed (0xA1…), start (0xA0,0,0), dir (0xA2,0x02,0x00).
- `dir_tick` during an in-flight dir frame. Required: exactly one more dir frame follows, carrying `dir` as sampled at its start.
- HB_CYCLES=50, `link_en`=1, no requests. Required: frame 0xA3,0,0 starts 52 cycles after reset release. With `link_en`=0 there are no frames.
- TIMEOUT_CYCLES=100, no `rx_frame_valid`:
  - Required: `con_error` rises at cycle 100 and stays high.
  - Pulse `err_clear`: `con_error` = 0.
  - Pulse `rx_frame_valid` every 90 cycles: `con_error` never rises.
- `rst` asserted while byte 1 is in WAIT_DONE. Required: next cycle state IDLE with no pending flags; `frame_sent` never pulses.

Source files
------------

// File: rtl/link_scheduler_pkg.sv
// Shared types for the link scheduler: direction, message types, frame layout and FSM states.
package link_scheduler_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } direction;

  typedef enum logic [1:0] {
    START = 2'd0,
    SEED  = 2'd1,
    DIR   = 2'd2,
    HB    = 2'd3
  } msg_type;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_DONE
  } sched_state;

  localparam logic [3:0] FRAME_HDR = 4'hA;
  localparam int         FRAME_LEN = 3;

  typedef logic [FRAME_LEN-1:0][7:0] frame_t;

endpackage

// File: rtl/link_scheduler_if.sv
// Byte handshake between the link scheduler and the uart_tx byte sender.
interface link_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  modport master (output tx_start, output tx_data, input tx_busy);
  modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/link_scheduler_watchdog.sv
// Receive-side watchdog: counts cycles since the last good frame and raises a sticky con_error.
module link_watchdog
  import link_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 37_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic link_en,
  input  logic rx_frame_valid,
  input  logic err_clear,
  output logic con_error
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             timeout;

  // Saturating increment; timeout fires on the edge the count lands on the limit.
  assign cnt_inc = (cnt == LIMIT) ? cnt : cnt + 1'b1;
  assign timeout = link_en && !rx_frame_valid && (cnt_inc == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      con_error <= 1'b0;
    end else begin
      if (!link_en || rx_frame_valid || (err_clear && timeout)) cnt <= '0;
      else                                                      cnt <= cnt_inc;
      if (err_clear)    con_error <= 1'b0;
      else if (timeout) con_error <= 1'b1;
    end
  end

endmodule

// File: rtl/link_scheduler.sv
// Arbitrates seed/start/dir/heartbeat messages onto the single uart_tx byte sender as
// 3-byte frames, and hosts the receive-side link watchdog.
module link_scheduler
  import link_scheduler_pkg::*;
#(
  parameter int HB_CYCLES      = 7_500_000,
  parameter int TIMEOUT_CYCLES = 37_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       link_en,
  input  logic       seed_rdy,
  input  logic [4:0] seed_x,
  input  logic [4:0] seed_y,
  input  logic       start_req,
  input  logic       dir_tick,
  input  direction   dir,
  input  logic       rx_frame_valid,
  input  logic       err_clear,
  link_if.master     tx,
  output logic       frame_busy,
  output logic       frame_sent,
  output logic       con_error
);
  localparam int              HB_W     = $clog2(HB_CYCLES + 1);
  localparam logic [HB_W-1:0] HB_LAST  = HB_W'(HB_CYCLES - 1);
  localparam logic [1:0]      LAST_IDX = 2'(FRAME_LEN - 1);

  sched_state      state, state_d;
  logic            p_seed, p_start, p_dir, p_hb, any_pend;
  logic [4:0]      seed_x_q, seed_y_q;
  frame_t          frame_q, frame_d;
  logic [1:0]      idx, idx_d;
  logic [HB_W-1:0] hb_cnt;
  logic            hb_count_en, hb_hit, select;
  msg_type         sel_type;
  logic            tx_start_d, frame_sent_d, frame_busy_d;
  logic [7:0]      tx_data_d;

  function automatic frame_t build_frame(msg_type t, logic [4:0] sx, logic [4:0] sy, direction d);
    frame_t f;
    f    = '0;
    f[0] = {FRAME_HDR, 2'b00, t};
    case (t)
      SEED: begin
        f[1] = {3'b000, sx};
        f[2] = {3'b000, sy};
      end
      DIR:     f[1] = {6'b000000, d};
      default: ;
    endcase
    return f;
  endfunction

  assign any_pend    = p_seed | p_start | p_dir | p_hb;
  assign hb_count_en = link_en && (state == S_IDLE) && !any_pend && !frame_sent;
  assign hb_hit      = hb_count_en && (hb_cnt == HB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      tx.tx_start    <= 1'b0;
      tx.tx_data     <= 8'h00;
      frame_busy     <= 1'b0;
      frame_sent     <= 1'b0;
    end else begin
      state          <= state_d;
      idx            <= idx_d;
      tx.tx_start    <= tx_start_d;
      tx.tx_data     <= tx_data_d;
      frame_busy     <= frame_busy_d;
      frame_sent     <= frame_sent_d;
    end
    frame_q <= frame_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:      if (any_pend && !tx.tx_busy) state_d = S_SEND;
      S_SEND:      state_d = S_WAIT_ACK;
      S_WAIT_ACK:  if (tx.tx_busy) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (!tx.tx_busy) state_d = (idx == LAST_IDX) ? S_IDLE : S_SEND;
      default:     state_d = S_IDLE;
    endcase
  end

  // Frame contents are frozen at selection; dir is sampled here, not at request time.
  always_comb begin
    sel_type = HB;
    if (p_seed)       sel_type = SEED;
    else if (p_start) sel_type = START;
    else if (p_dir)   sel_type = DIR;
    select  = (state == S_IDLE) && (state_d == S_SEND);
    frame_d = select ? build_frame(sel_type, seed_x_q, seed_y_q, dir) : frame_q;
    idx_d   = idx;
    if (select)                                           idx_d = '0;
    else if ((state == S_WAIT_DONE) && (state_d == S_SEND)) idx_d = idx + 1'b1;
    tx_start_d   = (state_d == S_SEND);
    tx_data_d    = tx_start_d ? frame_d[idx_d] : 8'h00;
    frame_sent_d = (state == S_WAIT_DONE) && (state_d == S_IDLE);
    frame_busy_d = (state_d != S_IDLE);
  end

  // A request landing on its own selection edge wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_seed  <= 1'b0;
      p_start <= 1'b0;
      p_dir   <= 1'b0;
      p_hb    <= 1'b0;
      hb_cnt  <= '0;
    end else begin
      p_seed  <= seed_rdy  | (p_seed  & ~(select && (sel_type == SEED)));
      p_start <= start_req | (p_start & ~(select && (sel_type == START)));
      p_dir   <= dir_tick  | (p_dir   & ~(select && (sel_type == DIR)));
      p_hb    <= hb_hit    | (p_hb    & ~(select && (sel_type == HB)));
      if (!link_en || frame_sent || hb_hit) hb_cnt <= '0;
      else if (hb_count_en)                 hb_cnt <= hb_cnt + 1'b1;
    end
    if (seed_rdy) begin
      seed_x_q <= seed_x;
      seed_y_q <= seed_y;
    end
  end

  link_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk            (clk),
    .rst            (rst),
    .link_en        (link_en),
    .rx_frame_valid (rx_frame_valid),
    .err_clear      (err_clear),
    .con_error      (con_error)
  );

endmodule

// File: tb/tb_link_scheduler.sv
// Self-checking bench for link_scheduler: directed scenarios plus a randomized run checked
// against a frame-level model of the pending flags and fixed priority.
`timescale 1ns/1ps
module tb_link_scheduler;
  import link_scheduler_pkg::*;

  localparam int HB = 50;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       link_en = 1'b0;
  logic       seed_rdy = 1'b0, start_req = 1'b0, dir_tick = 1'b0;
  logic [4:0] seed_x = '0, seed_y = '0;
  direction   dir = DIR_UP;
  logic       rx_frame_valid = 1'b0, err_clear = 1'b0;
  logic       frame_busy, frame_sent, con_error;

  int tests = 0;
  int fails = 0;
  int busy_cnt = 0;

  link_if tx();

  always #5 clk = ~clk;

  link_scheduler #(.HB_CYCLES(HB), .TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .link_en        (link_en),
    .seed_rdy       (seed_rdy),
    .seed_x         (seed_x),
    .seed_y         (seed_y),
    .start_req      (start_req),
    .dir_tick       (dir_tick),
    .dir            (dir),
    .rx_frame_valid (rx_frame_valid),
    .err_clear      (err_clear),
    .tx             (tx),
    .frame_busy     (frame_busy),
    .frame_sent     (frame_sent),
    .con_error      (con_error)
  );

  // uart_tx stand-in: busy for 10 cycles after each byte strobe.
  always @(posedge clk) begin
    if (rst)              busy_cnt <= 0;
    else if (tx.tx_start) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx.tx_busy = (busy_cnt != 0);

  // Leaves the bench in cycle 0: the first cycle with rst low, just after the last reset edge.
  task automatic apply_reset();
    rst = 1'b1;
    seed_rdy = 0; start_req = 0; dir_tick = 0; rx_frame_valid = 0; err_clear = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic get_byte(output logic [7:0] b, output bit ok);
    ok = 0; b = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx.tx_start) begin b = tx.tx_data; ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (tx.tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b, expected 0", tx.tx_start); end
    tests++; if (tx.tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h, expected 00", tx.tx_data); end
    tests++; if (frame_busy !== 1'b0) begin fails++; $display("FAIL reset_frame_busy: got %b, expected 0", frame_busy); end
    tests++; if (frame_sent !== 1'b0) begin fails++; $display("FAIL reset_frame_sent: got %b, expected 0", frame_sent); end
    tests++; if (con_error !== 1'b0) begin fails++; $display("FAIL reset_con_error: got %b, expected 0", con_error); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_seed_frame();
    logic [7:0] b1, b2;
    bit ok1, ok2;
    int sent;
    apply_reset();
    seed_x = 5'd17; seed_y = 5'd3; seed_rdy = 1;
    @(posedge clk); #1 seed_rdy = 0; seed_x = 5'($urandom); seed_y = 5'($urandom);
    @(posedge clk); @(negedge clk);
    tests++; if (tx.tx_start !== 1'b1) begin fails++; $display("FAIL seed_latency: tx_start got %b, expected 1 two cycles after request", tx.tx_start); end
    tests++; if (tx.tx_data !== 8'hA1) begin fails++; $display("FAIL seed_hdr: got %h, expected a1", tx.tx_data); end
    tests++; if (frame_busy !== 1'b1) begin fails++; $display("FAIL seed_busy: got %b, expected 1", frame_busy); end
    get_byte(b1, ok1);
    get_byte(b2, ok2);
    tests++; if (!ok1 || b1 !== 8'h11) begin fails++; $display("FAIL seed_b1: got %h (seen %0d), expected 11", b1, ok1); end
    tests++; if (!ok2 || b2 !== 8'h03) begin fails++; $display("FAIL seed_b2: got %h (seen %0d), expected 03", b2, ok2); end
    sent = 0;
    repeat (40) begin @(negedge clk); if (frame_sent) sent++; end
    tests++; if (sent !== 1) begin fails++; $display("FAIL seed_frame_sent: got %0d pulses, expected 1", sent); end
  endtask

  task automatic test_multi();
    logic [7:0] got, exp [9];
    logic [4:0] sx, sy;
    bit ok;
    apply_reset();
    sx = 5'($urandom); sy = 5'($urandom);
    exp = '{8'hA1, {3'b0, sx}, {3'b0, sy}, 8'hA0, 8'h00, 8'h00, 8'hA2, 8'h02, 8'h00};
    dir = DIR_DOWN; seed_x = sx; seed_y = sy;
    seed_rdy = 1; start_req = 1; dir_tick = 1;
    @(posedge clk); #1 seed_rdy = 0; start_req = 0; dir_tick = 0;
    for (int i = 0; i < 9; i++) begin
      get_byte(got, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL multi_timeout: byte %0d never sent", i); break; end
      if (got !== exp[i]) begin fails++; $display("FAIL multi_byte%0d: got %h, expected %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_dir_retrigger();
    direction da, db;
    logic [7:0] got, exp [6];
    bit ok;
    int extra;
    apply_reset();
    da = direction'($urandom_range(0, 3));
    db = direction'(2'(da) ^ 2'($urandom_range(1, 3)));
    exp = '{8'hA2, {6'b0, da}, 8'h00, 8'hA2, {6'b0, db}, 8'h00};
    dir = da; dir_tick = 1;
    @(posedge clk); #1 dir_tick = 0;
    for (int i = 0; i < 6; i++) begin
      get_byte(got, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL retrig_timeout: byte %0d never sent", i); break; end
      if (got !== exp[i]) begin fails++; $display("FAIL retrig_byte%0d: got %h, expected %h", i, got, exp[i]); end
      if (i == 0) begin @(posedge clk); #1 dir_tick = 1; @(posedge clk); #1 dir_tick = 0; end
      if (i == 2) dir = db;
    end
    extra = 0;
    repeat (80) begin @(negedge clk); if (tx.tx_start) extra++; end
    tests++; if (extra !== 0) begin fails++; $display("FAIL retrig_extra: got %0d extra bytes, expected 0", extra); end
  endtask

  task automatic test_heartbeat();
    int cyc, quiet;
    logic [7:0] b;
    bit ok;
    link_en = 1;
    apply_reset();
    cyc = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (tx.tx_start) begin cyc = n; break; end
    end
    // Cycle 51 counted from 0 is the 52nd cycle after release.
    tests++; if (cyc !== 51) begin fails++; $display("FAIL hb_start_cycle: got %0d, expected 51", cyc); end
    tests++; if (tx.tx_data !== 8'hA3) begin fails++; $display("FAIL hb_hdr: got %h, expected a3", tx.tx_data); end
    for (int i = 1; i < 3; i++) begin
      get_byte(b, ok);
      tests++; if (!ok || b !== 8'h00) begin fails++; $display("FAIL hb_byte%0d: got %h (seen %0d), expected 00", i, b, ok); end
    end
    link_en = 0;
    apply_reset();
    quiet = 0;
    repeat (300) begin @(negedge clk); if (tx.tx_start || frame_busy) quiet++; end
    tests++; if (quiet !== 0) begin fails++; $display("FAIL hb_disabled: got %0d active cycles, expected 0", quiet); end
  endtask

  task automatic test_watchdog();
    int cyc, lows, highs;
    link_en = 1;
    apply_reset();
    cyc = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (con_error) begin cyc = n; break; end
    end
    tests++; if (cyc !== 100) begin fails++; $display("FAIL wd_rise_cycle: got %0d, expected 100", cyc); end
    lows = 0;
    repeat (30) begin @(negedge clk); if (!con_error) lows++; end
    tests++; if (lows !== 0) begin fails++; $display("FAIL wd_sticky: got %0d low cycles, expected 0", lows); end
    @(posedge clk); #1 err_clear = 1;
    @(posedge clk); #1 err_clear = 0;
    @(negedge clk);
    tests++; if (con_error !== 1'b0) begin fails++; $display("FAIL wd_clear: got %b, expected 0", con_error); end
    highs = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1 rx_frame_valid = ((i % 90) == 89);
      @(negedge clk); if (con_error) highs++;
    end
    rx_frame_valid = 0;
    tests++; if (highs !== 0) begin fails++; $display("FAIL wd_fed: got %0d error cycles, expected 0", highs); end
    link_en = 0;
  endtask

  task automatic test_clear_vs_timeout();
    int cyc;
    link_en = 1;
    apply_reset();
    repeat (99) @(posedge clk);
    #1 err_clear = 1;
    @(posedge clk); #1 err_clear = 0;
    @(negedge clk);
    tests++; if (con_error !== 1'b0) begin fails++; $display("FAIL clr_wins: got %b, expected 0", con_error); end
    cyc = -1;
    for (int n = 101; n < 400; n++) begin
      @(negedge clk);
      if (con_error) begin cyc = n; break; end
    end
    tests++; if (cyc !== 200) begin fails++; $display("FAIL clr_restart: rise at %0d, expected 200", cyc); end
    link_en = 0;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    bit ok;
    int act, sent;
    link_en = 0;
    apply_reset();
    dir_tick = 1;
    @(posedge clk); #1 dir_tick = 0;
    get_byte(b, ok);
    get_byte(b, ok);
    tests++; if (!ok) begin fails++; $display("FAIL midrst_byte1: byte 1 never sent"); end
    @(posedge clk); #1 start_req = 1;
    @(posedge clk); #1 start_req = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    tests++; if (frame_busy !== 1'b0 || tx.tx_start !== 1'b0 || tx.tx_data !== 8'h00)
      begin fails++; $display("FAIL midrst_state: busy=%b start=%b data=%h, expected 0 0 00", frame_busy, tx.tx_start, tx.tx_data); end
    act = 0; sent = 0;
    repeat (150) begin @(negedge clk); if (tx.tx_start) act++; if (frame_sent) sent++; end
    tests++; if (act !== 0) begin fails++; $display("FAIL midrst_flags: got %0d bytes after reset, expected 0", act); end
    tests++; if (sent !== 0) begin fails++; $display("FAIL midrst_sent: got %0d frame_sent pulses, expected 0", sent); end
  endtask

  // Model: per-type pending bits; each frame start takes the highest-priority pending type.
  task automatic test_random();
    logic [3:0] pend;
    logic [4:0] m_sx, m_sy;
    logic [7:0] exp_q [$];
    logic [7:0] e;
    int mon_idx, frames;
    logic c_seed, c_start, c_dir;
    logic [4:0] c_sx, c_sy;
    direction c_d;
    bit draining;
    link_en = 0;
    apply_reset();
    pend = '0; m_sx = '0; m_sy = '0; mon_idx = 0; frames = 0; draining = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      c_seed = seed_rdy; c_start = start_req; c_dir = dir_tick;
      c_sx = seed_x; c_sy = seed_y; c_d = dir;
      @(posedge clk);
      #1;
      draining = (cyc >= 3000);
      seed_rdy  = !draining && ($urandom_range(0, 59) == 0);
      start_req = !draining && ($urandom_range(0, 79) == 0);
      dir_tick  = !draining && ($urandom_range(0, 29) == 0);
      seed_x = 5'($urandom); seed_y = 5'($urandom);
      if ($urandom_range(0, 7) == 0) dir = direction'($urandom_range(0, 3));
      @(negedge clk);
      if (tx.tx_start && mon_idx == 0) begin
        tests++;
        frames++;
        if (pend == 0) begin fails++; $display("FAIL rand_spurious: frame started with nothing pending"); end
        else if (pend[SEED])  begin exp_q.push_back(8'hA1); exp_q.push_back({3'b0, m_sx}); exp_q.push_back({3'b0, m_sy}); pend[SEED] = 0; end
        else if (pend[START]) begin exp_q.push_back(8'hA0); exp_q.push_back(8'h00); exp_q.push_back(8'h00); pend[START] = 0; end
        else                  begin exp_q.push_back(8'hA2); exp_q.push_back({6'b0, c_d}); exp_q.push_back(8'h00); pend[DIR] = 0; end
      end
      if (c_seed) begin pend[SEED] = 1; m_sx = c_sx; m_sy = c_sy; end
      if (c_start) pend[START] = 1;
      if (c_dir) pend[DIR] = 1;
      if (tx.tx_start) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL rand_unexpected: got %h, expected no byte", tx.tx_data); end
        else begin
          e = exp_q.pop_front();
          if (tx.tx_data !== e) begin fails++; $display("FAIL rand_byte: got %h, expected %h", tx.tx_data, e); end
        end
        mon_idx = (mon_idx + 1) % 3;
      end
      if (draining && pend == 0 && exp_q.size() == 0 && !frame_busy) break;
    end
    tests++; if (pend !== 4'b0 || exp_q.size() != 0 || frame_busy !== 1'b0)
      begin fails++; $display("FAIL rand_drain: pend=%b queued=%0d busy=%b, expected 0 0 0", pend, exp_q.size(), frame_busy); end
    tests++; if (frames < 20) begin fails++; $display("FAIL rand_activity: got %0d frames, expected at least 20", frames); end
  endtask

  initial begin
    test_reset();
    test_seed_frame();
    test_multi();
    test_dir_retrigger();
    test_heartbeat();
    test_watchdog();
    test_clear_vs_timeout();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
